// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side stream block.
// Default widths and the 2-bit skid-buffer occupancy encoding.
package fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_CNT_WIDTH  = 16;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_0 = 2'd0;
   localparam occ_t OCC_1 = 2'd1;
   localparam occ_t OCC_2 = 2'd2;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream and counters.
// master is the fifo_rd_stream side; slave is the FIFO/sink environment.
interface fifo_rd_stream_if import fifo_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
);

   logic [DATA_WIDTH-1:0] RD_DATA;
   logic                  EMPTY;
   logic                  R_INC;
   logic [DATA_WIDTH-1:0] OUT_DATA;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic                  FLUSH;
   logic [CNT_WIDTH-1:0]  DELIV_CNT;
   logic [CNT_WIDTH-1:0]  DROP_CNT;

   modport master (
      input  RD_DATA, EMPTY, OUT_READY, FLUSH,
      output R_INC, OUT_DATA, OUT_VALID, DELIV_CNT, DROP_CNT
   );

   modport slave (
      output RD_DATA, EMPTY, OUT_READY, FLUSH,
      input  R_INC, OUT_DATA, OUT_VALID, DELIV_CNT, DROP_CNT
   );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: head drives the stream, tail absorbs one word of backpressure.
// Valid is a dedicated flop so the stream valid never comes from decode logic.
module fifo_skid_buf import fifo_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] pop_data,
   input  logic                  xfer,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] head,
   output occ_t                  occ,
   output logic                  valid
);

   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   occ_t                  occ_q, occ_d;
   logic                  valid_q, valid_d;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      unique case (occ_q)
         OCC_0: begin
            if (pop) begin
               head_d = pop_data;
               occ_d  = OCC_1;
            end
         end
         OCC_1: begin
            if (pop && !xfer) begin
               tail_d = pop_data;
               occ_d  = OCC_2;
            end else if (pop && xfer) begin
               head_d = pop_data;
            end else if (xfer) begin
               occ_d = OCC_0;
            end
         end
         OCC_2: begin
            // pop is blocked at occ 2, so only the tail can refill the head
            if (xfer) begin
               head_d = tail_q;
               occ_d  = OCC_1;
            end
         end
         default: occ_d = OCC_0;
      endcase
      if (flush) begin
         occ_d = OCC_0;
      end
      valid_d = (occ_d != OCC_0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= OCC_0;
         valid_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         valid_q <= valid_d;
      end
   end

   assign head  = head_q;
   assign occ   = occ_q;
   assign valid = valid_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: pops the async FIFO into a skid buffer and streams it out.
// Adds synchronous flush, a wrapping delivered counter and a saturating dropped counter.
module fifo_rd_stream import fifo_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input logic             R_CLK,
   input logic             R_RST,
   fifo_rd_stream_if.master bus
);

   occ_t                 occ;
   logic                 pop;
   logic                 xfer;
   logic [1:0]           drop_amt;
   logic [CNT_WIDTH:0]   drop_sum;
   logic [CNT_WIDTH-1:0] deliv_q, deliv_d;
   logic [CNT_WIDTH-1:0] drop_q, drop_d;

   assign xfer = bus.OUT_VALID & bus.OUT_READY;

   // Depends only on EMPTY, FLUSH and registered occupancy; OUT_READY never reaches R_INC.
   assign pop       = ~bus.EMPTY & (occ < OCC_2) & ~bus.FLUSH & R_RST;
   assign bus.R_INC = pop;

   fifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk      (R_CLK),
      .rst      (R_RST),
      .pop      (pop),
      .pop_data (bus.RD_DATA),
      .xfer     (xfer),
      .flush    (bus.FLUSH),
      .head     (bus.OUT_DATA),
      .occ      (occ),
      .valid    (bus.OUT_VALID)
   );

   // A same-cycle transfer is a delivery, so it is excluded from the drop amount.
   assign drop_amt = occ - {1'b0, xfer};

   always_comb begin
      deliv_d  = deliv_q + CNT_WIDTH'(xfer);
      drop_sum = {1'b0, drop_q} + (CNT_WIDTH + 1)'(drop_amt);
      drop_d   = drop_q;
      if (bus.FLUSH) begin
         drop_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge R_CLK) begin
      if (!R_RST) begin
         deliv_q <= '0;
         drop_q  <= '0;
      end else begin
         deliv_q <= deliv_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.DELIV_CNT = deliv_q;
   assign bus.DROP_CNT  = drop_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized checks for fifo_rd_stream against a simple FIFO model.
// A second instance with 4-bit counters exposes counter wrap and saturation quickly.
module tb_fifo_rd_stream;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fifo_rd_stream_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
   fifo_rd_stream_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  bus_n ();

   fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .R_CLK (clk),
      .R_RST (rst),
      .bus   (bus)
   );

   fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_n (
      .R_CLK (clk),
      .R_RST (rst),
      .bus   (bus_n)
   );

   // FIFO model: circular memory with free-running pointers
   logic [7:0]  mem [256];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   logic        empty_force = 1'b0;

   assign bus.EMPTY     = (wr_ptr == rd_ptr) | empty_force;
   assign bus.RD_DATA   = mem[rd_ptr[7:0]];
   assign bus_n.EMPTY   = bus.EMPTY;
   assign bus_n.RD_DATA = bus.RD_DATA;
   assign bus_n.OUT_READY = bus.OUT_READY;
   assign bus_n.FLUSH   = bus.FLUSH;

   int errors = 0;
   int checks = 0;

   logic       inc_s, empty_s, valid_s, ready_s;
   logic [7:0] data_s;
   int         pops = 0;
   int         inc_empty_err = 0;
   logic [7:0] got [$];

   task automatic push(input logic [7:0] d);
      mem[wr_ptr[7:0]] = d;
      wr_ptr++;
   endtask

   // One clock: sample pre-edge, advance the model pointer if the DUT popped.
   task automatic step();
      #1;
      inc_s   = bus.R_INC;
      empty_s = bus.EMPTY;
      valid_s = bus.OUT_VALID;
      ready_s = bus.OUT_READY;
      data_s  = bus.OUT_DATA;
      if (inc_s && empty_s) inc_empty_err++;
      if (valid_s && ready_s) got.push_back(data_s);
      @(posedge clk);
      #1;
      if (inc_s) begin
         rd_ptr++;
         pops++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.OUT_READY = 1'b0;
      bus.FLUSH = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      pops = 0;
      repeat (3) step();
      checks++;
      if (pops !== 0) begin
         errors++; $display("FAIL reset_rinc: pops=%0d expected 0", pops);
      end
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", bus.OUT_VALID);
      end
      checks++;
      if (bus.DELIV_CNT !== 16'd0) begin
         errors++; $display("FAIL reset_deliv: got %0h expected 0", bus.DELIV_CNT);
      end
      checks++;
      if (bus.DROP_CNT !== 16'd0) begin
         errors++; $display("FAIL reset_drop: got %0h expected 0", bus.DROP_CNT);
      end
   endtask

   task automatic test_streaming();
      int bad;
      rst = 1'b1;
      bus.OUT_READY = 1'b1;
      got.delete();
      step();
      checks++;
      if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'h01) begin
         errors++;
         $display("FAIL stream_first: valid=%b data=%0h expected 1/01", bus.OUT_VALID, bus.OUT_DATA);
      end
      repeat (8) step();
      checks++;
      if (got.size() !== 8) begin
         errors++; $display("FAIL stream_b2b: %0d transfers expected 8", got.size());
      end
      bad = 0;
      foreach (got[i]) if (got[i] !== 8'(i + 1)) bad++;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL stream_order: %0d wrong words expected 0", bad);
      end
      step();
      checks++;
      if (bus.DELIV_CNT !== 16'd8 || bus.OUT_VALID !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: deliv=%0d valid=%b expected 8/0", bus.DELIV_CNT, bus.OUT_VALID);
      end
      checks++;
      if (inc_empty_err !== 0) begin
         errors++; $display("FAIL stream_rinc_empty: %0d pops on empty expected 0", inc_empty_err);
      end
   endtask

   task automatic test_backpressure();
      bus.OUT_READY = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
      pops = 0;
      repeat (5) step();
      checks++;
      if (pops !== 2 || bus.R_INC !== 1'b0) begin
         errors++; $display("FAIL bp_pops: pops=%0d rinc=%b expected 2/0", pops, bus.R_INC);
      end
      checks++;
      if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'h10) begin
         errors++;
         $display("FAIL bp_hold: valid=%b data=%0h expected 1/10", bus.OUT_VALID, bus.OUT_DATA);
      end
      bus.OUT_READY = 1'b1;
      got.delete();
      repeat (6) step();
      checks++;
      if (got.size() !== 4) begin
         errors++; $display("FAIL bp_count: %0d words expected 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== 8'h10 + 8'(i)) begin
               errors++;
               $display("FAIL bp_order[%0d]: got %0h expected %0h", i, got[i], 8'h10 + 8'(i));
            end
         end
      end
      checks++;
      if (bus.DELIV_CNT !== 16'd12) begin
         errors++; $display("FAIL bp_deliv: got %0d expected 12", bus.DELIV_CNT);
      end
   endtask

   task automatic test_flush();
      bus.OUT_READY = 1'b0;
      push(8'h20); push(8'h21); push(8'h22);
      pops = 0;
      step(); step();
      checks++;
      if (pops !== 2) begin
         errors++; $display("FAIL flush_fill: pops=%0d expected 2", pops);
      end
      bus.FLUSH = 1'b1;
      bus.OUT_READY = 1'b1;
      got.delete();
      step();
      checks++;
      if (inc_s !== 1'b0 || got.size() !== 1 || got[0] !== 8'h20) begin
         errors++;
         $display("FAIL flush_xfer: rinc=%b n=%0d expected 0/1 word 20", inc_s, got.size());
      end
      checks++;
      if (bus.OUT_VALID !== 1'b0 || bus.DELIV_CNT !== 16'd13 || bus.DROP_CNT !== 16'd1) begin
         errors++;
         $display("FAIL flush_state: valid=%b deliv=%0d drop=%0d expected 0/13/1",
                  bus.OUT_VALID, bus.DELIV_CNT, bus.DROP_CNT);
      end
      // occ is 0 and the FIFO is non-empty: only FLUSH can hold R_INC low here
      step();
      checks++;
      if (inc_s !== 1'b0 || bus.DROP_CNT !== 16'd1) begin
         errors++;
         $display("FAIL flush_gate: rinc=%b drop=%0d expected 0/1", inc_s, bus.DROP_CNT);
      end
      bus.FLUSH = 1'b0;
      step();
      checks++;
      if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 8'h22) begin
         errors++;
         $display("FAIL flush_keep_fifo: valid=%b data=%0h expected 1/22", bus.OUT_VALID, bus.OUT_DATA);
      end
      step(); step();
      checks++;
      if (bus.DELIV_CNT !== 16'd14) begin
         errors++; $display("FAIL flush_deliv: got %0d expected 14", bus.DELIV_CNT);
      end
   endtask

   task automatic test_boundary();
      bus.OUT_READY = 1'b1;
      push(8'h30); push(8'h31); push(8'h32);
      repeat (5) step();
      checks++;
      if (bus_n.DELIV_CNT !== 4'h1 || bus.DELIV_CNT !== 16'd17) begin
         errors++;
         $display("FAIL deliv_wrap: narrow=%0h wide=%0d expected 1/17", bus_n.DELIV_CNT, bus.DELIV_CNT);
      end
      for (int r = 0; r < 7; r++) begin
         bus.OUT_READY = 1'b0;
         push(8'h40); push(8'h41);
         step(); step();
         bus.FLUSH = 1'b1;
         step();
         bus.FLUSH = 1'b0;
      end
      checks++;
      if (bus_n.DROP_CNT !== 4'hF || bus.DROP_CNT !== 16'd15) begin
         errors++;
         $display("FAIL drop_at_max: narrow=%0h wide=%0d expected f/15", bus_n.DROP_CNT, bus.DROP_CNT);
      end
      push(8'h50); push(8'h51);
      step(); step();
      bus.FLUSH = 1'b1;
      step();
      bus.FLUSH = 1'b0;
      checks++;
      if (bus_n.DROP_CNT !== 4'hF) begin
         errors++; $display("FAIL drop_sat: narrow=%0h expected f", bus_n.DROP_CNT);
      end
      checks++;
      if (bus.DROP_CNT !== 16'd17 || bus_n.DELIV_CNT !== 4'h1) begin
         errors++;
         $display("FAIL drop_wide: wide drop=%0d narrow deliv=%0h expected 17/1",
                  bus.DROP_CNT, bus_n.DELIV_CNT);
      end
   endtask

   task automatic test_random();
      int unsigned deliv_idx, start_idx;
      int          order_err, stab_err;
      logic        pv, pr;
      logic [7:0]  pd, d;
      deliv_idx = rd_ptr;
      start_idx = rd_ptr;
      order_err = 0;
      stab_err  = 0;
      inc_empty_err = 0;
      pv = 1'b0; pr = 1'b0; pd = '0;
      got.delete();
      for (int c = 0; c < 10000; c++) begin
         bus.OUT_READY = ($urandom_range(0, 3) != 0);
         empty_force   = ($urandom_range(0, 3) == 0);
         if ((wr_ptr - rd_ptr) < 200 && $urandom_range(0, 1) == 1) push(8'($urandom_range(0, 255)));
         step();
         if (pv && !pr && (!valid_s || data_s !== pd)) stab_err++;
         pv = valid_s; pr = ready_s; pd = data_s;
         while (got.size() > 0) begin
            d = got.pop_front();
            if (d !== mem[deliv_idx[7:0]]) order_err++;
            deliv_idx++;
         end
      end
      empty_force   = 1'b0;
      bus.OUT_READY = 1'b1;
      repeat (260) step();
      while (got.size() > 0) begin
         d = got.pop_front();
         if (d !== mem[deliv_idx[7:0]]) order_err++;
         deliv_idx++;
      end
      checks++;
      if (order_err !== 0) begin
         errors++; $display("FAIL rand_order: %0d wrong words expected 0", order_err);
      end
      checks++;
      if (deliv_idx !== wr_ptr) begin
         errors++; $display("FAIL rand_drain: delivered up to %0d expected %0d", deliv_idx, wr_ptr);
      end
      checks++;
      if (stab_err !== 0) begin
         errors++; $display("FAIL rand_stall_stable: %0d changes under stall expected 0", stab_err);
      end
      checks++;
      if (inc_empty_err !== 0) begin
         errors++; $display("FAIL rand_rinc_empty: %0d pops on empty expected 0", inc_empty_err);
      end
      checks++;
      if (bus.DELIV_CNT !== 16'(17 + (deliv_idx - start_idx))) begin
         errors++;
         $display("FAIL rand_deliv: got %0d expected %0d", bus.DELIV_CNT,
                  16'(17 + (deliv_idx - start_idx)));
      end
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin
         errors++; $display("FAIL rand_idle: valid=%b expected 0", bus.OUT_VALID);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      bus.OUT_READY = 1'b0;
      bus.FLUSH = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_boundary();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the asynchronous FIFO. It runs entirely in the read clock domain.
- Drains the FIFO read port (RD_DATA / EMPTY / R_INC) and presents the words downstream as a registered valid/ready stream.
- Uses a 2-entry skid buffer, so the stream keeps full throughput while OUT_VALID and OUT_DATA come straight from flops.
- Also provides a synchronous flush, a delivered-word counter and a dropped-word counter.

Parameters:
- DATA_WIDTH, 8: width of a FIFO word and of OUT_DATA.
- CNT_WIDTH, 16: width of the DELIV_CNT and DROP_CNT counters.

Ports:
- R_CLK  in  1  read-domain clock.
- R_RST  in  1  synchronous active-low reset.
- RD_DATA  in  DATA_WIDTH  FIFO head word. Combinational from the FIFO memory at the current read address; valid whenever EMPTY=0.
- EMPTY  in  1  FIFO empty flag, already synchronised into the read domain.
- R_INC  out  1  pop request to the FIFO read pointer logic.
- OUT_DATA  out  DATA_WIDTH  stream data, registered.
- OUT_VALID  out  1  stream valid, registered.
- OUT_READY  in  1  downstream accept.
- FLUSH  in  1  synchronous discard of all buffered words.
- DELIV_CNT  out  CNT_WIDTH  count of words transferred downstream. Wraps at 2^CNT_WIDTH.
- DROP_CNT  out  CNT_WIDTH  count of words discarded by FLUSH. Saturates at all-ones.

Behaviour:
- Reset: sampled on the R_CLK rising edge while R_RST=0.
  - occ=0, OUT_VALID=0, OUT_DATA=0, tail=0, DELIV_CNT=0, DROP_CNT=0.
  - R_INC=0 while R_RST=0.
  - Reset mid-stream discards buffered words and does not update DROP_CNT.
- Storage: head register (drives OUT_DATA) and tail register; occupancy occ is 0..2. OUT_VALID = (occ != 0), held as a flop.
- Handshake:
  - xfer = OUT_VALID & OUT_READY.
  - Once OUT_VALID=1, OUT_VALID and OUT_DATA stay stable until xfer (except on FLUSH or reset).
- Pop: R_INC = !EMPTY & (occ < 2) & !FLUSH & R_RST.
  - Combinational, from the EMPTY input and registered occ only; no path from OUT_READY.
  - A pop captures RD_DATA at the same edge the FIFO read pointer advances. Latency from FIFO not-empty to OUT_VALID is 1 R_CLK.
- Occupancy transitions (pop = R_INC), all at the clock edge:
  - occ0, pop: head<=RD_DATA, occ=1.
  - occ1, pop, no xfer: tail<=RD_DATA, occ=2.
  - occ1, pop and xfer: head<=RD_DATA, occ=1.
  - occ1, xfer, no pop: occ=0.
  - occ2, xfer: head<=tail, occ=1. No pop is possible in this state.
  - occ2, no xfer: hold.
- Throughput: 1 word/cycle sustained while EMPTY=0 and OUT_READY=1.
- FLUSH (priority over pop):
  - Next state occ=0, OUT_VALID=0, R_INC=0 that cycle.
  - An xfer in the same cycle is a valid delivery: it is counted in DELIV_CNT, and the remaining words are dropped.
  - DROP_CNT += occ - xfer, saturating.
  - FLUSH does not touch FIFO contents.
- Counters:
  - DELIV_CNT += 1 on each xfer, with modulo wrap.
  - DROP_CNT saturates at all-ones.
  - Both are registered and update the cycle after the event.
- EMPTY boundary: EMPTY is evaluated per cycle. An EMPTY 1->0 transition pops in that same cycle if occ<2. Never pop while EMPTY=1.
- OUT_DATA holds its last value when OUT_VALID=0; the bench does not check OUT_DATA in that state.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH and CNT_WIDTH constants;
  - occupancy encoding constants OCC_0, OCC_1, OCC_2 (2-bit).
- One natural sub-module: fifo_skid_buf (head/tail registers and occ). The top adds pop logic, flush and counters.
- Integration: instantiated beside the FIFO top. R_INC, RD_DATA and EMPTY connect to the FIFO read port, clocked by R_CLK with the same R_RST.

Test Plan:
- Reset: hold R_RST=0 for 3 cycles with EMPTY=0 -> R_INC=0, OUT_VALID=0, DELIV_CNT=0, DROP_CNT=0.
- Streaming: FIFO model pre-loaded with 0x01..0x08, OUT_READY=1 -> first OUT_VALID one cycle after reset release, then 0x01..0x08 on consecutive cycles, DELIV_CNT=8, no R_INC while EMPTY=1.
- Backpressure: 0x10..0x13 queued, OUT_READY=0 for 5 cycles ->
  - exactly 2 pops and R_INC then 0;
  - OUT_DATA held at 0x10;
  - on release, data follows in order 0x10..0x13 with no loss or duplication.
- Flush: occ=2 (0x20, 0x21), FLUSH=1 with OUT_READY=1 -> 0x20 delivered, DELIV_CNT +1, DROP_CNT=1, OUT_VALID=0 next cycle, R_INC=0 in the FLUSH cycle.
- Boundaries: DELIV_CNT forced near 0xFFFF, 2 transfers -> DELIV_CNT wraps to 0x0001. DROP_CNT at 0xFFFF plus a flush of 2 -> stays 0xFFFF.
- Random EMPTY toggling with random OUT_READY over 10k cycles -> scoreboard output order matches FIFO order, OUT_VALID/OUT_DATA are stable under stall, and R_INC is never asserted while EMPTY=1.
